// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instruction_fetch_pkg : shared constants and state encoding for the fetch unit
// Revision : 1.0
// ---------------------------------------------------------------------------
package instruction_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam int          DEPTH_DEFAULT    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_fifo : small instruction buffer with push/pop/flush; head shows NOP when empty
// Revision : 1.0
// ---------------------------------------------------------------------------
module fetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [31:0]   head_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_push    = push && !full && !flush;
    assign w_pop     = pop && !empty && !flush;
    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = empty ? INSTR_NOP : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instruction_fetch : PC generation, request throttling and redirect/drain control
// Revision : 1.0
// ---------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = DEPTH_DEFAULT
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    output logic        O_imem_req,
    output logic [31:0] O_imem_addr,
    input  logic        I_imem_gnt,
    input  logic        I_imem_rvalid,
    input  logic [31:0] I_imem_rdata,
    output logic        O_valid,
    input  logic        I_ready,
    output logic [31:0] O_instr,
    output logic [31:0] O_pc,
    input  logic        I_redirect,
    input  logic [31:0] I_redirect_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e  r_state;
    fetch_state_e  w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_head_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;
    logic          r_req;
    logic [CW-1:0] w_out_nxt;
    logic [CW-1:0] w_drop_nxt;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_fire;
    logic          w_accept;
    logic          w_redirect;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [31:0]   w_target;
    logic [31:0]   w_head;

    assign w_fire      = r_req && I_imem_gnt;
    assign w_accept    = I_imem_rvalid && (r_outstanding != '0);
    assign w_redirect  = I_redirect && (r_state != ST_IDLE);
    assign w_target    = align_word(I_redirect_pc);
    // Responses are only kept in RUN; a same-cycle redirect discards them too.
    assign w_push      = w_accept && (r_state == ST_RUN) && !w_redirect;
    assign w_pop       = !w_empty && I_ready && !w_redirect;
    assign w_out_nxt   = r_outstanding + CW'(w_fire) - CW'(w_accept);
    assign w_count_nxt = w_redirect ? '0 : (w_count + CW'(w_push) - CW'(w_pop));

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (I_clk),
        .rst_n     (I_rst_n),
        .push      (w_push),
        .push_data (I_imem_rdata),
        .pop       (w_pop),
        .flush     (w_redirect),
        .head_data (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_redirect) begin
                    w_drop_nxt  = w_out_nxt;
                    w_state_nxt = (w_out_nxt != '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_accept && (r_drop != '0)) w_drop_nxt = r_drop - CW'(1);
                if (w_drop_nxt == '0) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The request is registered from next-cycle occupancy, which equals the
    // current buffered+outstanding check once the edge has passed.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state       <= ST_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_head_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_req         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_drop        <= w_drop_nxt;
            r_outstanding <= w_out_nxt;
            r_req         <= (w_state_nxt == ST_RUN) &&
                             ((int'(w_count_nxt) + int'(w_out_nxt)) < DEPTH);
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_head_pc  <= w_target;
            end else begin
                if (w_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_pop)  r_head_pc  <= r_head_pc + 32'd4;
            end
        end
    end

    assign O_imem_req  = r_req;
    assign O_imem_addr = r_fetch_pc;
    assign O_valid     = !w_empty;
    assign O_instr     = w_head;
    assign O_pc        = r_head_pc;

    a_rvalid_expected: assert property (@(posedge I_clk) disable iff (!I_rst_n)
        I_imem_rvalid |-> (r_outstanding != '0));
    a_no_overflow: assert property (@(posedge I_clk) disable iff (!I_rst_n)
        !(w_push && w_full));

endmodule
`default_nettype wire
